alu_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares a single combinational 32-bit ALU (opcode/enable in; result/ack out; result tri-stated when disabled) between NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU enable only while an operation executes. It then captures the result on ack and returns it with the requester ID. A watchdog flags an error response if the ALU never acks.

---
 rtl/alu_share_ctrl_pkg.sv | 28 ++
 rtl/alu_share_ctrl_if.sv | 44 ++++
 rtl/alu_share_ctrl_rr_arbiter.sv | 33 +++
 rtl/alu_share_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Purpose: shared types and default sizes for the ALU sharing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_OP_W        = 3;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_INC    = 3'b010,
        OP_DEC    = 3'b011,
        OP_PASS_A = 3'b100,
        OP_NOT_A  = 3'b101,
        OP_OR     = 3'b110,
        OP_AND    = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Purpose: bundles requester, response and ALU-side signals of the controller.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
interface alu_share_ctrl_if
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [IDW-1:0]            rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [OP_W-1:0]           alu_opcode;
    logic                      alu_enable;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_ack;

    // Controller side.
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_ack,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               alu_a, alu_b, alu_opcode, alu_enable
    );

    // Environment side: requesters, response consumer and the ALU itself.
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_ack,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               alu_a, alu_b, alu_opcode, alu_enable
    );

endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Purpose: round-robin one-hot grant starting after the last granted requester.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is honoured.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_vld
);

    logic [IDW-1:0] cand;

    // Scan from last_grant+1 upward with wrap; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Purpose: shares one combinational ALU between NUM_REQ requesters, one op in flight.
// Latency: response valid one edge after ALU ack (two edges after accept with immediate ack).
// Backpressure: response held until rsp_ready; no new request accepted until then.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int OP_W        = DEF_OP_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    ctrl_state_e       state_q, state_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              alu_en_q, alu_en_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic              rsp_err_q, rsp_err_d;
    logic [WDW-1:0]    wdog_q, wdog_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_vld;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_vld    (gnt_vld)
    );

    // Grant is only offered in IDLE and never while reset is asserted.
    assign bus.req_ready  = (state_q == IDLE && rst_n) ? gnt : '0;
    assign bus.rsp_valid  = rsp_vld_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_enable = alu_en_q;

    // Next-state and registered-output logic of the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_data_d   = rsp_data_q;
        alu_en_d     = alu_en_q;
        rsp_vld_d    = rsp_vld_q;
        rsp_err_d    = rsp_err_q;
        wdog_d       = wdog_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d      = EXEC;
                    last_grant_d = gnt_idx;
                    rsp_id_d     = gnt_idx;
                    alu_a_d      = bus.req_a[int'(gnt_idx)*DATA_W +: DATA_W];
                    alu_b_d      = bus.req_b[int'(gnt_idx)*DATA_W +: DATA_W];
                    alu_op_d     = bus.req_op[int'(gnt_idx)*OP_W +: OP_W];
                    alu_en_d     = 1'b1;
                    wdog_d       = '0;
                end
            end
            EXEC: begin
                // Ack is checked first so it wins over a simultaneous expiry.
                if (bus.alu_ack || wdog_q == WDW'(TIMEOUT_CYC - 1)) begin
                    state_d    = RESP;
                    rsp_data_d = bus.alu_ack ? bus.alu_result : '0;
                    rsp_err_d  = !bus.alu_ack;
                    rsp_vld_d  = 1'b1;
                    alu_en_d   = 1'b0;
                    alu_a_d    = '0;
                    alu_b_d    = '0;
                    alu_op_d   = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d   = IDLE;
                    rsp_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any op and drops enable at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_data_q   <= '0;
            alu_en_q     <= 1'b0;
            rsp_vld_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_data_q   <= rsp_data_d;
            alu_en_q     <= alu_en_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_err_q    <= rsp_err_d;
            wdog_q       <= wdog_d;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Purpose: randomized and directed self-check of alu_share_ctrl against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: exercises rsp_ready stalls and ALU ack delays up to and past the timeout.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int OW    = 3;
    localparam int TO    = 16;
    localparam int NEVER = 99;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) bus ();

    alu_share_ctrl #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT_CYC(TO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ptr;
    int ack_delay = 0;
    int en_cnt    = 0;
    logic [DW-1:0] last_data;
    logic [DW-1:0] a_arr [N];
    logic [DW-1:0] b_arr [N];
    logic [OW-1:0] op_arr[N];
    logic [DW-1:0] sweep_exp[8];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [DW-1:0] alu_ref(input logic [OW-1:0] op,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (alu_op_e'(op))
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_INC:    return a + 1;
            OP_DEC:    return a - 1;
            OP_PASS_A: return a;
            OP_NOT_A:  return ~a;
            OP_OR:     return a | b;
            default:   return a & b;
        endcase
    endfunction

    function automatic int model_grant(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Pack per-requester operands onto the flat request buses.
    always_comb begin
        bus.req_a  = '0;
        bus.req_b  = '0;
        bus.req_op = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*DW +: DW]  = a_arr[i];
            bus.req_b[i*DW +: DW]  = b_arr[i];
            bus.req_op[i*OW +: OW] = op_arr[i];
        end
    end

    // ALU model: acks after ack_delay enabled cycles; never acks (result Z) for NEVER.
    always_comb begin
        bus.alu_ack    = 1'b0;
        bus.alu_result = 'z;
        if (bus.alu_enable && ack_delay != NEVER) begin
            bus.alu_result = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);
            bus.alu_ack    = (en_cnt >= ack_delay);
        end
    end

    // Count consecutive enabled cycles for the delayed-ack model.
    always @(posedge clk) en_cnt <= bus.alu_enable ? en_cnt + 1 : 0;

    // One full transaction: offer mask, expect model grant, follow to response.
    task automatic run_txn(input logic [N-1:0] mask, input int delay, input int stall);
        int exp_id, en_cyc, exp_cyc;
        logic [DW-1:0] exp_data;
        logic exp_err, got, busy_rdy, unstable;
        logic [DW-1:0] hold_data;
        logic [N-1:0]  hold_id;
        ack_delay     = delay;
        bus.rsp_ready = (stall == 0);
        bus.req_valid = mask;
        #1;
        exp_id = model_grant(mask);
        check("grant", bus.req_ready, 64'(1) << exp_id);
        ptr = exp_id;
        if (delay >= TO) begin
            exp_cyc = TO; exp_data = '0; exp_err = 1'b1;
        end else begin
            exp_cyc  = delay + 1;
            exp_data = alu_ref(op_arr[exp_id], a_arr[exp_id], b_arr[exp_id]);
            exp_err  = 1'b0;
        end
        @(posedge clk); #1;
        bus.req_valid = bus.req_valid & ~(N'(1) << exp_id);
        en_cyc = 0; got = 1'b0; busy_rdy = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
            else begin
                if (bus.alu_enable) en_cyc++;
                if (bus.req_ready != '0) busy_rdy = 1'b1;
            end
        end
        check("rsp_seen", got, 1);
        check("exec_cycles", en_cyc, exp_cyc);
        check("rdy_busy", busy_rdy, 0);
        check("rsp_id", bus.rsp_id, exp_id);
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_err", bus.rsp_err, exp_err);
        check("en_in_resp", bus.alu_enable, 0);
        check("alu_a_in_resp", bus.alu_a, 0);
        last_data = bus.rsp_data;
        hold_data = bus.rsp_data;
        hold_id   = N'(bus.rsp_id);
        unstable  = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== hold_data || N'(bus.rsp_id) !== hold_id ||
                bus.rsp_err !== exp_err || bus.req_ready != '0) unstable = 1'b1;
        end
        if (stall > 0) check("stall_stable", unstable, 0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_drop", bus.rsp_valid, 0);
    endtask

    initial begin
        logic [N-1:0] mask;
        int r, dly;
        sweep_exp = '{32'd15, 32'd5, 32'd11, 32'd9, 32'd10, 32'hFFFF_FFF5, 32'd15, 32'd0};
        for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; op_arr[i] = '0; end
        rst_n = 1'b0; bus.req_valid = '1; bus.rsp_ready = 1'b0; ptr = N - 1;
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_alu_enable", bus.alu_enable, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_alu_a", bus.alu_a, 0);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op on requester 0.
        a_arr[0] = 32'd10; b_arr[0] = 32'd5; op_arr[0] = OP_ADD;
        run_txn(4'b0001, 0, 0);
        check("single_data", last_data, 32'd15);

        // Opcode sweep on requester 1.
        a_arr[1] = 32'd10; b_arr[1] = 32'd5;
        for (int k = 0; k < 8; k++) begin
            op_arr[1] = OW'(k);
            run_txn(4'b0010, 0, 0);
            check("sweep_data", last_data, sweep_exp[k]);
        end

        // Timeout then a normal op on the same requester.
        a_arr[2] = 32'd7; b_arr[2] = 32'd3; op_arr[2] = OP_ADD;
        run_txn(4'b0100, NEVER, 0);
        run_txn(4'b0100, 0, 0);
        check("after_timeout", last_data, 32'd10);

        // Ack arriving on the same edge the watchdog expires.
        run_txn(4'b0100, TO - 1, 0);

        // Backpressure on a SUB result of 5.
        a_arr[3] = 32'd10; b_arr[3] = 32'd5; op_arr[3] = OP_SUB;
        run_txn(4'b1000, 0, 5);
        check("bp_data", last_data, 32'd5);

        // Request withdrawn before the accepting edge leaves the controller idle.
        bus.req_valid = 4'b0100;
        #1;
        check("drop_offer", bus.req_ready, 4'b0100);
        bus.req_valid = '0;
        @(posedge clk); #1;
        check("drop_no_exec", bus.alu_enable, 0);

        // Reset in the middle of EXEC.
        ack_delay = 5; bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0010;
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("mid_exec_en", bus.alu_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_en_async", bus.alu_enable, 0);
        check("rst_alu_op", bus.alu_opcode, 0);
        check("rst_rsp_valid2", bus.rsp_valid, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        ptr = N - 1;
        @(negedge clk);
        rst_n = 1'b1;
        r = 0;
        repeat (4) begin @(negedge clk); if (bus.rsp_valid) r = 1; end
        check("no_rsp_after_rst", r, 0);
        @(posedge clk); #1;

        // Contention: all requesters valid, distinct ops.
        op_arr[0] = OP_ADD; op_arr[1] = OP_SUB; op_arr[2] = OP_OR; op_arr[3] = OP_AND;
        for (int i = 0; i < N; i++) begin a_arr[i] = $urandom; b_arr[i] = $urandom; end
        repeat (5) run_txn(4'b1111, 0, 0);

        // Randomized traffic.
        repeat (40) begin
            for (int i = 0; i < N; i++) begin
                a_arr[i] = $urandom; b_arr[i] = $urandom; op_arr[i] = OW'($urandom_range(0, 7));
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            r = $urandom_range(0, 9);
            if (r < 6)       dly = r % 4;
            else if (r < 8)  dly = $urandom_range(4, 14);
            else if (r == 8) dly = TO - 1;
            else             dly = NEVER;
            run_txn(mask, dly, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
